// File: rtl/cfo_calc.sv
// cfo_calc: CFO estimator, vectoring CORDIC on conj(C0)*C1 of the two half-PSS correlations.
// Macro CFO_CALC_DDS_INC_EN enables the DDS increment output; otherwise it is tied to 0.
module cfo_calc #(
    parameter int C_DW   = 80,
    parameter int CFO_DW = 24,
    parameter int DDS_DW = 20
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [C_DW-1:0]   C0_i,
    input  logic [C_DW-1:0]   C1_i,
    input  logic              valid_i,
    output logic [CFO_DW-1:0] CFO_angle_o,
    output logic [DDS_DW-1:0] CFO_DDS_inc_o,
    output logic              valid_o
);
    localparam int H  = C_DW / 2;
    localparam int PW = C_DW + 2;
    localparam int NW = CFO_DW + 3;
    localparam int XW = CFO_DW + 5;
    localparam int ZW = CFO_DW + 2;
    localparam int KW = $clog2(CFO_DW);
    localparam int HW = $clog2(PW);
    localparam int AS = 31 - CFO_DW;
    localparam int SH = CFO_DW - DDS_DW + 6;
    localparam logic [HW-1:0] MT = HW'(NW - 2);
    // Accumulator carries one fractional bit: pi = 2^CFO_DW
    localparam logic signed [ZW-1:0] PI   = ZW'(1 << CFO_DW);
    localparam logic signed [ZW-1:0] MAXA = ZW'((1 << (CFO_DW - 1)) - 1);
    localparam logic signed [ZW-1:0] MINA = -MAXA;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PROD = 3'd1;
    localparam logic [2:0] S_NORM = 3'd2;
    localparam logic [2:0] S_ITER = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [C_DW-1:0]      c0_q, c0_d, c1_q, c1_d;
    logic signed [PW-1:0] re_q, re_d, im_q, im_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic                 zero_q, zero_d;
    logic [CFO_DW-1:0]    ang_q, ang_d;
    logic                 valid_q, valid_d;

    logic signed [PW-1:0] a0, b0, a1, b1;
    logic [PW-1:0]        mag;
    logic [HW-1:0]        msb;
    logic signed [NW-1:0] re_n, im_n;
    logic signed [XW-1:0] xs, ys;
    logic signed [ZW-1:0] at, zr;

    // atan(2^-k) with pi = 2^31
    function automatic logic [31:0] atan_t(input int k);
        case (k)
            0:  return 32'd536870912;
            1:  return 32'd316933406;
            2:  return 32'd167458907;
            3:  return 32'd85004756;
            4:  return 32'd42667331;
            5:  return 32'd21354465;
            6:  return 32'd10679838;
            7:  return 32'd5340245;
            8:  return 32'd2670163;
            9:  return 32'd1335087;
            10: return 32'd667544;
            11: return 32'd333772;
            12: return 32'd166886;
            13: return 32'd83443;
            14: return 32'd41722;
            15: return 32'd20861;
            16: return 32'd10430;
            17: return 32'd5215;
            18: return 32'd2608;
            19: return 32'd1304;
            20: return 32'd652;
            21: return 32'd326;
            22: return 32'd163;
            23: return 32'd81;
            24: return 32'd41;
            25: return 32'd20;
            26: return 32'd10;
            27: return 32'd5;
            28: return 32'd3;
            29: return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    assign a0 = PW'($signed(c0_q[H-1:0]));
    assign b0 = PW'($signed(c0_q[C_DW-1:H]));
    assign a1 = PW'($signed(c1_q[H-1:0]));
    assign b1 = PW'($signed(c1_q[C_DW-1:H]));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        re_d    = re_q;
        im_d    = im_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        ang_d   = ang_q;
        valid_d = 1'b0;
        mag     = (re_q[PW-1] ? -re_q : re_q) | (im_q[PW-1] ? -im_q : im_q);
        msb     = '0;
        for (int i = 0; i < PW; i++)
            if (mag[i]) msb = HW'(i);
        re_n = NW'((msb >= MT) ? re_q >>> (msb - MT) : re_q <<< (MT - msb));
        im_n = NW'((msb >= MT) ? im_q >>> (msb - MT) : im_q <<< (MT - msb));
        xs   = x_q >>> k_q;
        ys   = y_q >>> k_q;
        at   = ZW'((33'(atan_t(int'(k_q))) + 33'(1 << (AS - 1))) >> AS);
        zr   = (z_q + ZW'(1)) >>> 1;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    c0_d    = C0_i;
                    c1_d    = C1_i;
                    state_d = S_PROD;
                end
            end
            S_PROD: begin
                re_d    = a0 * a1 + b0 * b1;
                im_d    = a0 * b1 - b0 * a1;
                state_d = S_NORM;
            end
            S_NORM: begin
                // Left half-plane: rotate by pi so CORDIC only sees |angle| < pi/2
                zero_d  = (mag == '0);
                x_d     = re_q[PW-1] ? -XW'(re_n) : XW'(re_n);
                y_d     = re_q[PW-1] ? -XW'(im_n) : XW'(im_n);
                z_d     = re_q[PW-1] ? (im_q[PW-1] ? -PI : PI) : ZW'(0);
                k_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                x_d     = y_q[XW-1] ? x_q - ys : x_q + ys;
                y_d     = y_q[XW-1] ? y_q + xs : y_q - xs;
                z_d     = y_q[XW-1] ? z_q - at : z_q + at;
                k_d     = k_q + KW'(1);
                state_d = (k_q == KW'(CFO_DW - 1)) ? S_DONE : S_ITER;
            end
            S_DONE: begin
                ang_d   = zero_q ? '0 : CFO_DW'(zr > MAXA ? MAXA : (zr < MINA ? MINA : zr));
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            re_q    <= '0;
            im_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            ang_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            re_q    <= re_d;
            im_q    <= im_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            ang_q   <= ang_d;
            valid_q <= valid_d;
        end
    end

    assign CFO_angle_o = ang_q;
    assign valid_o     = valid_q;

`ifdef CFO_CALC_DDS_INC_EN
    logic [DDS_DW-1:0] inc_q, inc_d;

    assign inc_d = (state_q == S_DONE) ?
                   DDS_DW'((ZW'($signed(ang_d)) + ZW'(1 << (SH - 1))) >>> SH) : inc_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) inc_q <= '0;
        else inc_q <= inc_d;
    end

    assign CFO_DDS_inc_o = inc_q;
`else
    assign CFO_DDS_inc_o = '0;
`endif
endmodule

// File: tb/tb_cfo_calc.sv
// tb_cfo_calc: scoreboard bench for cfo_calc with directed, hand-computed vectors.
module tb_cfo_calc;
    logic        clk_i    = 1'b0;
    logic        reset_ni = 1'b1;
    logic        valid_i  = 1'b0;
    logic [79:0] C0_i     = '0;
    logic [79:0] C1_i     = '0;
    logic [23:0] CFO_angle_o;
    logic [19:0] CFO_DDS_inc_o;
    logic        valid_o;

    typedef struct {
        int ang;
        int atol;
        int inc;
        int itol;
        int due;
    } exp_t;

`ifdef CFO_CALC_DDS_INC_EN
    localparam bit INC_ON = 1'b1;
`else
    localparam bit INC_ON = 1'b0;
`endif

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    logic chk_zero = 1'b0;
    logic done     = 1'b0;

    cfo_calc #(.C_DW(80), .CFO_DW(24), .DDS_DW(20)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .C0_i         (C0_i),
        .C1_i         (C1_i),
        .valid_i      (valid_i),
        .CFO_angle_o  (CFO_angle_o),
        .CFO_DDS_inc_o(CFO_DDS_inc_o),
        .valid_o      (valid_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [79:0] cx(input longint re, input longint im);
        return {40'(im), 40'(re)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", nm, act, exp, tol);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("missing_valid_o", cyc, sb[0].due, 0);
            void'(sb.pop_front());
        end
        if (valid_o) begin
            if (sb.size() == 0) chk("unexpected_valid_o", int'(valid_o), 0, 0);
            else begin
                e = sb.pop_front();
                chk("latency", cyc, e.due, 0);
                chk("angle", int'($signed(CFO_angle_o)), e.ang, e.atol);
                chk("inc", int'($signed(CFO_DDS_inc_o)), e.inc, e.itol);
            end
        end
        if (chk_zero) begin
            chk("rst_angle", int'($signed(CFO_angle_o)), 0, 0);
            chk("rst_inc", int'($signed(CFO_DDS_inc_o)), 0, 0);
            chk("rst_valid", int'(valid_o), 0, 0);
        end
        if (done) begin
            chk("pending", sb.size(), 0, 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Called at a negedge; valid_i is sampled on the next posedge.
    task automatic send(input longint a0, input longint b0, input longint a1, input longint b1,
                        input bit push, input int ang, input int atol, input int inc, input int itol);
        C0_i    = cx(a0, b0);
        C1_i    = cx(a1, b1);
        valid_i = 1'b1;
        if (push) sb.push_back('{ang, atol, INC_ON ? inc : 0, INC_ON ? itol : 0, cyc + 28});
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic wait_c(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic zero_check();
        @(posedge clk_i);
        chk_zero = 1'b1;
        @(posedge clk_i);
        chk_zero = 1'b0;
    endtask

    initial begin
        #1 reset_ni = 1'b0;
        wait_c(3);
        zero_check();
        @(negedge clk_i);
        reset_ni = 1'b1;
        wait_c(2);
        send(1000, 0, 0, 1000, 1, 4194304, 4, 4096, 1);
        wait_c(29);
        send(3000, -4000, 3000, -4000, 1, 0, 4, 0, 0);
        wait_c(29);
        send(1000, 0, -1000, 1, 1, 8385938, 4, 8189, 1);
        wait_c(29);
        send(1000, 0, -1000, -1, 1, -8385938, 4, -8189, 1);
        wait_c(29);
        send(1000, 0, -1000, 0, 1, 8388607, 4, 8192, 1);
        wait_c(29);
        send(0, 0, 1234, -567, 1, 0, 0, 0, 0);
        wait_c(29);
        send(1, 0, 0, 1, 1, 4194304, 4, 4096, 1);
        wait_c(29);
        send(64'sd274877906944, 0, 0, -64'sd274877906944, 1, -4194304, 4, -4096, 1);
        wait_c(29);
        send(1000, 0, 1000, 1000, 1, 2097152, 4, 2048, 1);
        wait_c(27);
        send(1000, 0, 1000, -1000, 1, -2097152, 4, -2048, 1);
        wait_c(29);
        send(1000, 0, 0, -1000, 1, -4194304, 4, -4096, 1);
        wait_c(4);
        send(1000, 0, 3000, 4000, 0, 0, 0, 0, 0);
        wait_c(29);
        send(1000, 0, 0, 1000, 0, 0, 0, 0, 0);
        wait_c(9);
        reset_ni = 1'b0;
        zero_check();
        @(negedge clk_i);
        reset_ni = 1'b1;
        wait_c(35);
        send(3000, -4000, -4000, -3000, 1, -4194304, 4, -4096, 1);
        wait_c(30);
        @(posedge clk_i);
        done = 1'b1;
    end
endmodule
